edge_event_capture: RTL
=======================

// Module: edge_event_capture
// PURPOSE
//  Multi-channel asynchronous-signal conditioner and edge-event recorder for the PL DMA
//  control path (DMA done/error lines, external triggers). Per channel: synchroniser,
//  glitch filter, selectable rise/fall/both edge qualification, stretchable pulse output,
//  sticky event flag and a saturating event counter for software/FSM consumption.
// PARAMETERS
//  CHANNELS      4  number of independent input channels (>=1)
//  SYNC_STAGES   2  synchroniser flop stages per channel (>=2)
//  FILTER_CYCLES 4  consecutive cycles a synced change must persist before acceptance (>=1)
//  PULSE_WIDTH   1  pulse_out high-time in clk cycles per qualified edge (>=1)
//  CNT_W         8  width of each per-channel event counter (>=1)
// PORTS
//  clk          in   1            clock; all logic posedge clk
//  rst          in   1            reset, synchronous, active-low
//  sig_in       in   CHANNELS     raw asynchronous inputs
//  edge_mode    in   2*CHANNELS   per ch [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  sticky_clr   in   CHANNELS     per-channel clear of event_sticky and event_count
//  level_out    out  CHANNELS     filtered, synchronised level
//  pulse_out    out  CHANNELS     stretched pulse on qualified edge
//  event_sticky out  CHANNELS     set on qualified edge, held until sticky_clr
//  event_any    out  1            OR of event_sticky (combinational from registers)
//  event_count  out  CHANNELS*CNT_W  ch i at [CNT_W*i +: CNT_W], saturating edge count
// BEHAVIOUR
//  - Reset (rst=0 at posedge): sync chain, filter counters, level_out, pulse_out,
//    stretch counters, event_sticky, event_count all 0; event_any=0. Reset wins over all.
//  - Sync: sig_in passes SYNC_STAGES flops; output "s" is last stage.
//  - Filter: per-ch counter counts cycles with s != level_out; cleared whenever s == level_out.
//    On the edge where s still differs and counter == FILTER_CYCLES-1, level_out toggles.
//    Latency sig_in step -> level_out: SYNC_STAGES+FILTER_CYCLES clocks. Pulses on s shorter
//    than FILTER_CYCLES cycles are discarded entirely.
//  - Edge: level toggle 0->1 = rise, 1->0 = fall. Qualified if enabled by edge_mode sampled
//    on the same clock. pulse_out, event_sticky, event_count update on the SAME edge that
//    level_out toggles (no extra latency).
//  - Stretch: qualified edge loads stretch counter with PULSE_WIDTH; pulse_out high while
//    counter > 0. A new qualified edge during stretch reloads (extends), never shortens.
//  - Mode change effective the next clock; mode 00 blocks new events but level_out tracks;
//    an in-progress stretch completes.
//  - Counter: +1 per qualified edge, saturates at 2^CNT_W-1 (no wrap).
//  - sticky_clr: clears sticky and count next edge. Same-cycle clear + qualified edge:
//    sticky=1, count=1 (event wins over clear).
//  - Input high at reset release: level_out starts 0, so a rising edge is reported after
//    the normal latency (intentional: reports lines already asserted).
//  - Reset mid-stretch or mid-filter: all state returns to reset values next edge.
// TESTING (defaults unless stated)
//  1 rst=0 5 clks with sig_in=4'hF, mode=8'h55, release -> outputs 0 during reset;
//    level_out=4'hF and pulse_out=4'hF (1 clk) 6 clks after release; count ch0..3 = 1.
//  2 ch0 sync-level high 3 clks then low -> no level/pulse/count change; high 4 clks ->
//    one rise pulse, then fall toggles level only (mode 01); count=1.
//  3 ch1 mode 10, 0->1->0 -> single pulse on fall; mode 11 same stimulus -> two pulses,
//    count=2; mode 00 -> level_out toggles, no pulse, count unchanged.
//  4 PULSE_WIDTH=3: two rises 2 clks apart (FILTER_CYCLES=1) -> pulse_out high 5 clks
//    contiguous; isolated rise -> exactly 3 clks.
//  5 300 rises on ch2 -> event_count ch2 = 255, sticky=1, event_any=1; sticky_clr same clk
//    as a rise -> sticky=1, count=1; clr alone -> sticky=0, count=0, event_any=0.
//  6 rst=0 in 2nd clk of a 3-clk stretch and mid-filter -> all outputs 0 next edge, no
//    residual pulse or level change after release with sig_in=0.

Source files
------------

// File: rtl/edge_event_capture.sv
// Multi-channel input conditioner: synchroniser, glitch filter, edge qualification,
// stretched pulse, sticky flag and saturating event counter per channel.
module edge_event_capture #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int PULSE_WIDTH   = 1,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       sig_in,
  input  logic [2*CHANNELS-1:0]     edge_mode,
  input  logic [CHANNELS-1:0]       sticky_clr,
  output logic [CHANNELS-1:0]       level_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       event_sticky,
  output logic                      event_any,
  output logic [CHANNELS*CNT_W-1:0] event_count
);

  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam int STR_W = $clog2(PULSE_WIDTH + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  logic [FLT_W-1:0]    flt_cnt_q [CHANNELS];
  logic [FLT_W-1:0]    flt_cnt_d [CHANNELS];
  logic [STR_W-1:0]    str_cnt_q [CHANNELS];
  logic [STR_W-1:0]    str_cnt_d [CHANNELS];
  logic [CNT_W-1:0]    evt_cnt_q [CHANNELS];
  logic [CNT_W-1:0]    evt_cnt_d [CHANNELS];

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] sticky_q, sticky_d;
  logic [CHANNELS-1:0] toggle, qual;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [STR_W-1:0] str_dec(input logic [STR_W-1:0] v);
    return (v == '0) ? v : v - STR_W'(1);
  endfunction

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    toggle   = '0;
    qual     = '0;
    level_d  = level_q;
    pulse_d  = '0;
    sticky_d = sticky_q;
    for (int c = 0; c < CHANNELS; c++) begin
      flt_cnt_d[c] = flt_cnt_q[c];
      str_cnt_d[c] = str_cnt_q[c];
      evt_cnt_d[c] = evt_cnt_q[c];

      // A synced change is accepted only after persisting FILTER_CYCLES edges
      toggle[c] = (s[c] != level_q[c]) && (flt_cnt_q[c] == FLT_LAST);
      if ((s[c] == level_q[c]) || toggle[c]) begin
        flt_cnt_d[c] = '0;
      end else begin
        flt_cnt_d[c] = flt_cnt_q[c] + FLT_W'(1);
      end
      level_d[c] = level_q[c] ^ toggle[c];

      // level_q=0 before the toggle means a rise, otherwise a fall
      qual[c] = toggle[c] && (level_q[c] ? edge_mode[2*c+1] : edge_mode[2*c]);

      str_cnt_d[c] = qual[c] ? STR_LOAD : str_dec(str_cnt_q[c]);
      pulse_d[c]   = (str_cnt_d[c] != '0);

      // A qualified edge wins over a same-cycle clear
      if (qual[c]) begin
        sticky_d[c]  = 1'b1;
        evt_cnt_d[c] = sticky_clr[c] ? CNT_W'(1) : sat_inc(evt_cnt_q[c]);
      end else if (sticky_clr[c]) begin
        sticky_d[c]  = 1'b0;
        evt_cnt_d[c] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        flt_cnt_q[c] <= '0;
        str_cnt_q[c] <= '0;
        evt_cnt_q[c] <= '0;
      end
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        flt_cnt_q[c] <= flt_cnt_d[c];
        str_cnt_q[c] <= str_cnt_d[c];
        evt_cnt_q[c] <= evt_cnt_d[c];
      end
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign level_out    = level_q;
  assign pulse_out    = pulse_q;
  assign event_sticky = sticky_q;
  assign event_any    = |sticky_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    assign event_count[CNT_W*g +: CNT_W] = evt_cnt_q[g];
  end

endmodule
